// File: rtl/mire_pkg.sv
// Shared types and constants for the mire_gen test-pattern generator.
// Optional frame-offset animation is enabled with `MIRE_ANIM_EN.
package mire_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_GRID  = 2'd0,
      M_BARS  = 2'd1,
      M_GRAD  = 2'd2,
      M_SOLID = 2'd3
   } mode_t;

   localparam logic [23:0] BAR_COL [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle with clock and reset carried alongside.
// Master side drives the cycle, slave side returns ack.
interface wshb_if (
   input logic clk,
   input logic rst
);

   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;

   modport master (
      input  clk, rst, ack,
      output cyc, stb, we, sel, adr, dat_ms, cti, bte
   );

   modport slave (
      input  clk, rst, cyc, stb, we, sel, adr, dat_ms, cti, bte,
      output ack
   );

endinterface

// File: rtl/mire_pattern.sv
// Combinational pixel colour for one (pixel, line) position and pattern mode.
// The offset input animates the pattern when `MIRE_ANIM_EN is set upstream.
module mire_pattern
   import mire_pkg::*;
#(
   parameter int PW   = 10,
   parameter int LW   = 9,
   parameter int GRID = 16
) (
   input  logic [PW-1:0] pix_i,
   input  logic [LW-1:0] line_i,
   input  logic [2:0]    bar_i,
   input  logic [1:0]    mode_i,
   input  logic [15:0]   off_i,
   input  logic [23:0]   solid_i,
   output logic [23:0]   rgb_o
);

   // GRID is a power of two, so the modulo is a mask.
   localparam logic [15:0] GMASK = 16'(GRID - 1);

   logic       gx;
   logic       gy;
   logic [7:0] gv;
   logic [2:0] bi;

   always_comb begin
      gx    = ((16'(pix_i) + off_i) & GMASK) == 16'd0;
      gy    = ((16'(line_i) + off_i) & GMASK) == 16'd0;
      gv    = 8'(16'(pix_i) + off_i);
      bi    = bar_i + off_i[2:0];
      rgb_o = solid_i;
      unique case (mode_t'(mode_i))
         M_GRID:  rgb_o = (gx || gy) ? 24'hFFFFFF : 24'h000000;
         M_BARS:  rgb_o = BAR_COL[bi];
         M_GRAD:  rgb_o = {gv, gv, gv};
         M_SOLID: rgb_o = solid_i;
         default: rgb_o = solid_i;
      endcase
   end

endmodule

// File: rtl/mire_gen.sv
// Wishbone-master test-pattern generator writing whole frames to a framebuffer.
// Define `MIRE_ANIM_EN to shift the pattern by the frame count each frame.
module mire_gen
   import mire_pkg::*;
#(
   parameter int          HDISP    = 800,
   parameter int          VDISP    = 480,
   parameter int          GRID     = 16,
   parameter logic [31:0] BASE_ADR = 32'h0
) (
   wshb_if.master      wshb_ifm,
   input  logic        run,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_col,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int PW  = cw(HDISP);
   localparam int LW  = cw(VDISP);
   localparam int BW  = HDISP / 8;
   localparam int BCW = cw(BW);

   localparam logic [PW-1:0]  PIX_LAST  = PW'(HDISP - 1);
   localparam logic [LW-1:0]  LINE_LAST = LW'(VDISP - 1);
   localparam logic [BCW-1:0] BCNT_LAST = BCW'(BW - 1);

   state_t         state_q, state_d;
   logic [PW-1:0]  pix_q, pix_d;
   logic [LW-1:0]  line_q, line_d;
   logic [2:0]     bar_q, bar_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic [1:0]     mode_q, mode_d;
   logic [23:0]    solid_q, solid_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           done_q, done_d;
   logic [31:0]    adr_q;
   logic [31:0]    dat_q;
   logic [31:0]    adr_nxt;
   logic [23:0]    rgb_nxt;
   logic [15:0]    off_d;
   logic           ld;
   logic           start;
   logic           last;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      line_d  = line_q;
      bar_d   = bar_q;
      bcnt_d  = bcnt_q;
      mode_d  = mode_q;
      solid_d = solid_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ld      = 1'b0;
      start   = 1'b0;
      last    = (pix_q == PIX_LAST) && (line_q == LINE_LAST);
      unique case (state_q)
         IDLE: begin
            if (run) start = 1'b1;
         end
         WRITE: begin
            if (wshb_ifm.ack) begin
               if (last) begin
                  state_d = GAP;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + 16'd1;
               end else begin
                  ld = 1'b1;
                  if (pix_q == PIX_LAST) begin
                     pix_d  = '0;
                     line_d = line_q + 1'b1;
                  end else begin
                     pix_d = pix_q + 1'b1;
                  end
                  // Bar index steps on bar boundaries; wraps 7->0 at line end.
                  if (bcnt_q == BCNT_LAST) begin
                     bcnt_d = '0;
                     bar_d  = bar_q + 3'd1;
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (run) start = 1'b1;
            else     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = WRITE;
         pix_d   = '0;
         line_d  = '0;
         bar_d   = '0;
         bcnt_d  = '0;
         mode_d  = mode;
         solid_d = solid_col;
         ld      = 1'b1;
      end
   end

`ifdef MIRE_ANIM_EN
   logic [15:0] off_q;

   always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
      if (wshb_ifm.rst) off_q <= '0;
      else if (start)   off_q <= cnt_q;
   end

   assign off_d = start ? cnt_q : off_q;
`else
   assign off_d = 16'd0;
`endif

   assign adr_nxt = BASE_ADR
      + ((32'(line_d) * 32'(HDISP) + 32'(pix_d)) << 2);

   // Pattern is evaluated for the next pixel so adr/dat register together.
   mire_pattern #(
      .PW   (PW),
      .LW   (LW),
      .GRID (GRID)
   ) u_pat (
      .pix_i   (pix_d),
      .line_i  (line_d),
      .bar_i   (bar_d),
      .mode_i  (mode_d),
      .off_i   (off_d),
      .solid_i (solid_d),
      .rgb_o   (rgb_nxt)
   );

   always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
      if (wshb_ifm.rst) begin
         state_q <= IDLE;
         pix_q   <= '0;
         line_q  <= '0;
         bar_q   <= '0;
         bcnt_q  <= '0;
         mode_q  <= '0;
         solid_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         bar_q   <= bar_d;
         bcnt_q  <= bcnt_d;
         mode_q  <= mode_d;
         solid_q <= solid_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (ld) begin
            adr_q <= adr_nxt;
            dat_q <= {8'h00, rgb_nxt};
         end
      end
   end

   assign wshb_ifm.cyc    = (state_q == WRITE);
   assign wshb_ifm.stb    = (state_q == WRITE);
   assign wshb_ifm.we     = 1'b1;
   assign wshb_ifm.sel    = 4'hF;
   assign wshb_ifm.cti    = 3'b000;
   assign wshb_ifm.bte    = 2'b00;
   assign wshb_ifm.adr    = adr_q;
   assign wshb_ifm.dat_ms = dat_q;

   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_mire_gen.sv
// Scoreboard bench for mire_gen: a frame-level reference model queues
// expected writes; a monitor pops and compares on every acked strobe.
module tb_mire_gen;

   localparam int          HD   = 32;
   localparam int          VD   = 4;
   localparam int          GR   = 8;
   localparam logic [31:0] BASE = 32'h100;
   localparam int          NPIX = HD * VD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] solid = 24'h0;
   logic        busy;
   logic        done;
   logic [15:0] fcnt;

   wshb_if wb (.clk(clk), .rst(rst));

   mire_gen #(
      .HDISP    (HD),
      .VDISP    (VD),
      .GRID     (GR),
      .BASE_ADR (BASE)
   ) dut (
      .wshb_ifm   (wb),
      .run        (run),
      .mode       (mode),
      .solid_col  (solid),
      .busy       (busy),
      .frame_done (done),
      .frame_cnt  (fcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t         sb[$];
   logic [15:0] dq[$];
   int          errors = 0;
   int          checks = 0;
   int          wr_in_frame = 0;
   int          model_frames = 0;
   bit          ack_rand = 1'b0;
   int          stall_left = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [23:0] ref_pix(input int p, input int l, input int m,
                                           input logic [23:0] sc, input int off);
      logic [7:0] v;
      int b;
      case (m)
         0: return (((p + off) % GR == 0) || ((l + off) % GR == 0)) ? 24'hFFFFFF : 24'h0;
         1: begin
            b = p / (HD / 8);
            return bars[(b + off) % 8];
         end
         2: begin
            v = 8'((p + off) % 256);
            return {v, v, v};
         end
         default: return sc;
      endcase
   endfunction

   task automatic push_frame(input int m, input logic [23:0] sc);
      int off;
      wr_t e;
`ifdef MIRE_ANIM_EN
      off = model_frames % 65536;
`else
      off = 0;
`endif
      for (int l = 0; l < VD; l++) begin
         for (int p = 0; p < HD; p++) begin
            e.adr = BASE + 32'(4 * (l * HD + p));
            e.dat = {8'h00, ref_pix(p, l, m, sc, off)};
            sb.push_back(e);
         end
      end
      model_frames++;
      dq.push_back(16'(model_frames));
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      chk("frame_done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_wr(input int target, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (wr_in_frame < target && n < budget);
      chk("write_count_timeout", {31'd0, (wr_in_frame >= target)}, 32'd1);
   endtask

   task automatic start_frame(input int m, input logic [23:0] sc);
      push_frame(m, sc);
      @(posedge clk);
      #1;
      run   = 1'b1;
      mode  = 2'(m);
      solid = sc;
      @(posedge clk);
      #1;
      run = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (!ack_rand) begin
         wb.ack = 1'b1;
      end else if (stall_left == 0) begin
         wb.ack     = 1'b1;
         stall_left = $urandom_range(0, 5);
      end else begin
         wb.ack = 1'b0;
         stall_left--;
      end
   end

   logic        prev_stall = 1'b0;
   logic [31:0] prev_adr;
   logic [31:0] prev_dat;
   wr_t         me;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && wb.stb) begin
            checks++;
            if (wb.adr !== prev_adr || wb.dat_ms !== prev_dat) begin
               errors++;
               $display("FAIL stall_stable: adr %h dat %h, held %h %h",
                        wb.adr, wb.dat_ms, prev_adr, prev_dat);
            end
         end
         if (wb.stb && wb.ack) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: adr %h dat %h, none queued",
                        wb.adr, wb.dat_ms);
            end else begin
               me = sb.pop_front();
               if (wb.adr !== me.adr || wb.dat_ms !== me.dat || wb.cyc !== 1'b1 ||
                   wb.we !== 1'b1 || wb.sel !== 4'hF || wb.cti !== 3'b000 ||
                   wb.bte !== 2'b00) begin
                  errors++;
                  $display("FAIL write: adr %h dat %h cyc %b we %b sel %h, expected adr %h dat %h",
                           wb.adr, wb.dat_ms, wb.cyc, wb.we, wb.sel, me.adr, me.dat);
               end
            end
            wr_in_frame++;
         end
         if (done) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: frame_cnt %h", fcnt);
            end else begin
               logic [15:0] ec;
               ec = dq.pop_front();
               if (fcnt !== ec) begin
                  errors++;
                  $display("FAIL frame_cnt: got %h expected %h", fcnt, ec);
               end
            end
            checks++;
            if (wr_in_frame != NPIX) begin
               errors++;
               $display("FAIL frame_len: got %0d writes expected %0d", wr_in_frame, NPIX);
            end
            wr_in_frame = 0;
         end
         prev_stall = wb.stb && !wb.ack;
         prev_adr   = wb.adr;
         prev_dat   = wb.dat_ms;
      end
   end

   initial begin
      int m;
      logic [23:0] sc;

      #1 rst = 1'b1;
      #2;
      chk("rst_cyc", {31'd0, wb.cyc}, 32'd0);
      chk("rst_stb", {31'd0, wb.stb}, 32'd0);
      chk("rst_adr", wb.adr, 32'd0);
      chk("rst_dat", wb.dat_ms, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cnt", {16'd0, fcnt}, 32'd0);
      chk("const_we", {31'd0, wb.we}, 32'd1);
      chk("const_sel", {28'd0, wb.sel}, 32'hF);
      chk("const_cti", {29'd0, wb.cti}, 32'd0);
      chk("const_bte", {30'd0, wb.bte}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Frame with ack held high, grid pattern
      ack_rand = 1'b0;
      start_frame(0, 24'h0);
      wait_done(1000);
      repeat (4) @(negedge clk);
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);
      chk("t1_drain", sb.size(), 32'd0);

      // Same frame under random ack stalls
      ack_rand = 1'b1;
      start_frame(0, 24'h0);
      wait_done(2000);
      chk("t2_drain", sb.size(), 32'd0);

      // Bars, with a mode change mid-frame that must not take effect
      start_frame(1, 24'h0);
      wait_wr(40, 2000);
      @(posedge clk);
      #1 mode = 2'd2;
      wait_done(2000);
      start_frame(2, 24'h0);
      wait_done(2000);

      // Back-to-back frames with run held, dropped during the third
      ack_rand = 1'b0;
      repeat (3) push_frame(1, 24'h0);
      @(posedge clk);
      #1;
      run  = 1'b1;
      mode = 2'd1;
      wait_done(1000);
      chk("gap1_low", {31'd0, wb.cyc}, 32'd0);
      @(negedge clk);
      chk("gap1_one", {31'd0, wb.cyc}, 32'd1);
      wait_done(1000);
      chk("gap2_low", {31'd0, wb.cyc}, 32'd0);
      @(negedge clk);
      chk("gap2_one", {31'd0, wb.cyc}, 32'd1);
      wait_wr(20, 1000);
      @(posedge clk);
      #1 run = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
      chk("cyc_hold", {31'd0, wb.cyc}, 32'd1);
      wait_done(1000);
      @(negedge clk);
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("t4_drain", sb.size(), 32'd0);

      // Asynchronous reset at pixel 50
      start_frame(0, 24'h0);
      wait_wr(50, 1000);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_cyc", {31'd0, wb.cyc}, 32'd0);
      chk("arst_stb", {31'd0, wb.stb}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_cnt", {16'd0, fcnt}, 32'd0);
      chk("arst_adr", wb.adr, 32'd0);
      sb.delete();
      dq.delete();
      wr_in_frame  = 0;
      model_frames = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      start_frame(0, 24'h0);
      wait_done(1000);

      // Second grid frame after reset (shifted when animation is built in)
      start_frame(0, 24'h0);
      wait_done(1000);

      // Randomised frames
      for (int k = 0; k < 5; k++) begin
         m        = $urandom_range(0, 3);
         sc       = 24'($urandom);
         ack_rand = 1'($urandom_range(0, 1));
         start_frame(m, sc);
         wait_done(2000);
      end

      repeat (5) @(negedge clk);
      chk("final_drain_sb", sb.size(), 32'd0);
      chk("final_drain_done", dq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
